// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds format bit indices, opcode constants, NOP word, request bundle, imm helper.
package inst_encoder_pkg;

    localparam int FMT_W = 6;
    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      imm;
    } enc_req_t;

    // True when v[31:sh] are all equal, i.e. v fits a signed (sh+1)-bit field.
    function automatic logic imm_fits(input logic [31:0] v, input int unsigned sh);
        logic [31:0] t;
        t = 32'($signed(v) >>> sh);
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packer: request fields + immediate -> instruction word and flag.
// Ports: i_req (request bundle), o_inst (word), o_err (flag, 0 unless INST_ENCODER_RANGE_CHECK_EN).
module inst_pack
    import inst_encoder_pkg::*;
(
    input  enc_req_t    i_req,
    output logic [31:0] o_inst,
    output logic        o_err
);

    logic [31:0] w_raw;
    logic [31:0] w_imm;

    assign w_imm = i_req.imm;

    always_comb begin
        w_raw = '0;
        // A zero or multi-hot format produces no word at all.
        if ($onehot(i_req.fmt)) begin
            unique case (1'b1)
                i_req.fmt[FMT_R]: w_raw = {i_req.funct7, i_req.rs2, i_req.rs1,
                                           i_req.funct3, i_req.rd, i_req.opcode};
                i_req.fmt[FMT_I]: w_raw = {w_imm[11:0], i_req.rs1, i_req.funct3,
                                           i_req.rd, i_req.opcode};
                i_req.fmt[FMT_S]: w_raw = {w_imm[11:5], i_req.rs2, i_req.rs1,
                                           i_req.funct3, w_imm[4:0], i_req.opcode};
                i_req.fmt[FMT_B]: w_raw = {w_imm[12], w_imm[10:5], i_req.rs2,
                                           i_req.rs1, i_req.funct3, w_imm[4:1],
                                           w_imm[11], i_req.opcode};
                i_req.fmt[FMT_U]: w_raw = {w_imm[31:12], i_req.rd, i_req.opcode};
                i_req.fmt[FMT_J]: w_raw = {w_imm[20], w_imm[10:1], w_imm[11],
                                           w_imm[19:12], i_req.rd, i_req.opcode};
                default:          w_raw = '0;
            endcase
        end
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic w_ok;
    logic w_bad;

    always_comb begin
        w_ok = 1'b0;
        if ($onehot(i_req.fmt)) begin
            unique case (1'b1)
                i_req.fmt[FMT_R]: w_ok = 1'b1;
                i_req.fmt[FMT_I]: w_ok = imm_fits(w_imm, 11);
                i_req.fmt[FMT_S]: w_ok = imm_fits(w_imm, 11);
                i_req.fmt[FMT_B]: w_ok = imm_fits(w_imm, 12) && !w_imm[0];
                i_req.fmt[FMT_U]: w_ok = (w_imm[11:0] == 12'h000);
                i_req.fmt[FMT_J]: w_ok = imm_fits(w_imm, 20) && !w_imm[0];
                default:          w_ok = 1'b0;
            endcase
        end
    end

    assign w_bad  = !w_ok;
    assign o_inst = w_bad ? INST_NOP : w_raw;
    assign o_err  = w_bad;
`else
    assign o_inst = w_raw;
    assign o_err  = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Two-stage pipelined RV32I encoder with valid/ready on both sides.
// Ports: i_clk, i_rst_n, i_valid/o_ready + fields in; o_valid/i_ready, o_inst, o_err, o_err_count out.
// Option: INST_ENCODER_RANGE_CHECK_EN enables legality flagging, NOP substitution and the counter.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [FMT_W-1:0]     i_format,
    input  logic [6:0]           i_opcode,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [31:0]          i_immediate,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_inst,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    enc_req_t    r_s1;
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic [31:0] r_inst;
    logic        r_err;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_accept;
    logic [31:0] w_inst;
    logic        w_err;
    enc_req_t    w_req;

    assign w_req = '{fmt: i_format, opcode: i_opcode, rd: i_rd, rs1: i_rs1,
                     rs2: i_rs2, funct3: i_funct3, funct7: i_funct7,
                     imm: i_immediate};

    // S2 can take a new word when empty or draining this cycle.
    assign w_s2_adv = !r_s2_valid || i_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign o_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept = i_valid && o_ready;

    inst_pack u_pack (
        .i_req  (r_s1),
        .o_inst (w_inst),
        .o_err  (w_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1       <= w_req;
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_inst     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_inst     <= w_inst;
                r_err      <= w_err;
            end else if (i_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_inst  = r_inst;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= '0;
        end else if (r_s2_valid && i_ready && r_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_err       = r_err;
    assign o_err_count = r_err_count;
`else
    // Flag path is inert without range checking; r_err stays 0.
    assign o_err       = r_err;
    assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
// Covers packing per format, legality handling, backpressure and mid-flight reset.
module tb_inst_encoder;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_format;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_immediate;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic        o_err;
    logic [7:0]  o_err_count;

    int errors = 0;
    int checks = 0;

    inst_encoder #(.ERR_CNT_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_format    (i_format),
        .i_opcode    (i_opcode),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_immediate (i_immediate),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_inst      (o_inst),
        .o_err       (o_err),
        .o_err_count (o_err_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        i_valid     = 1'b1;
        i_format    = f;
        i_opcode    = op;
        i_rd        = rd;
        i_rs1       = rs1;
        i_rs2       = rs2;
        i_funct3    = f3;
        i_funct7    = f7;
        i_immediate = imm;
    endtask

    // One request through an idle pipe with i_ready=1; checks latency and word.
    task automatic send_one(input string tag, input logic [5:0] f, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_err);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        i_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(o_valid), 32'd1);
        chk({tag, "_inst"}, o_inst, exp_inst);
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        step();
        chk({tag, "_drain"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b0;
        drive(6'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        i_valid = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cnt", 32'(o_err_count), 32'd0);
        i_rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(o_ready), 32'd1);

        send_one("addi", 6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
                 32'hFFF0_0093, 1'b0);
        send_one("beq", 6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,
                 32'h0020_8463, 1'b0);
        send_one("lui", 6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,
                 32'h1234_52B7, 1'b0);
        send_one("jal", 6'b100000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,
                 32'h0010_00EF, 1'b0);
        send_one("sub", 6'b000001, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF,
                 32'h4020_81B3, 1'b0);
        send_one("sw", 6'b000100, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC,
                 32'hFE20_AE23, 1'b0);
        send_one("beq6", 6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6,
                 32'h0020_8363, 1'b0);
        chk("cnt_legal", 32'(o_err_count), 32'd0);

`ifdef INST_ENCODER_RANGE_CHECK_EN
        send_one("i2048", 6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                 32'h0000_0013, 1'b1);
        chk("cnt1", 32'(o_err_count), 32'd1);
        send_one("beq7", 6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,
                 32'h0000_0013, 1'b1);
        chk("cnt2", 32'(o_err_count), 32'd2);
        send_one("multihot", 6'b000110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
                 32'h0000_0013, 1'b1);
        chk("cnt3", 32'(o_err_count), 32'd3);
        send_one("nofmt", 6'b000000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
                 32'h0000_0013, 1'b1);
        chk("cnt4", 32'(o_err_count), 32'd4);
`else
        send_one("i2048", 6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                 32'h8000_0093, 1'b0);
        send_one("beq7", 6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,
                 32'h0020_8363, 1'b0);
        send_one("multihot", 6'b000110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
                 32'h0000_0000, 1'b0);
        send_one("nofmt", 6'b000000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
                 32'h0000_0000, 1'b0);
        chk("cnt_off", 32'(o_err_count), 32'd0);
`endif

        // Backpressure: A, B accepted, C stalls until i_ready returns.
        i_ready = 1'b0;
        drive(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        chk("bp_rdyA", 32'(o_ready), 32'd1);
        step();
        drive(6'b000010, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        chk("bp_rdyB", 32'(o_ready), 32'd1);
        step();
        drive(6'b000010, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("bp_full", 32'(o_ready), 32'd0);
        chk("bp_vldA", 32'(o_valid), 32'd1);
        chk("bp_instA", o_inst, 32'h0010_0093);
        step();
        chk("bp_hold1", o_inst, 32'h0010_0093);
        chk("bp_full2", 32'(o_ready), 32'd0);
        step();
        chk("bp_hold2", o_inst, 32'h0010_0093);
        chk("bp_vhold", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        chk("bp_vldB", 32'(o_valid), 32'd1);
        chk("bp_instB", o_inst, 32'h0020_0113);
        step();
        chk("bp_vldC", 32'(o_valid), 32'd1);
        chk("bp_instC", o_inst, 32'h0030_0193);
        step();
        chk("bp_empty", 32'(o_valid), 32'd0);

        // Reset with two entries in flight.
        i_ready = 1'b0;
        drive(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        drive(6'b000010, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        step();
        i_valid = 1'b0;
        chk("mid_full", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_vld", 32'(o_valid), 32'd0);
        chk("mid_cnt", 32'(o_err_count), 32'd0);
        chk("mid_inst", o_inst, 32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("mid_rdy", 32'(o_ready), 32'd1);
        send_one("post", 6'b000010, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4,
                 32'h0040_0213, 1'b0);
        chk("post_cnt", 32'(o_err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Pipelined RV32I instruction encoder, the inverse of the decoder's immediate generator.
- Takes instruction fields plus a 32-bit sign-extended immediate and a one-hot format, and packs them into a 32-bit instruction word.
- Feeds the instruction-memory preload path and self-test stimulus generator.
- Two-stage pipeline, valid/ready on both sides, immediate legality checking.

Parameters:
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  request valid.
- o_ready  output  1  encoder can accept a request this cycle.
- i_format  input  6  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J.
- i_opcode  input  7  opcode field.
- i_rd  input  5  destination register.
- i_rs1  input  5  source register 1.
- i_rs2  input  5  source register 2.
- i_funct3  input  3  funct3 field.
- i_funct7  input  7  funct7 field (R-type only).
- i_immediate  input  32  sign-extended immediate.
- o_valid  output  1  encoded word valid.
- i_ready  input  1  downstream accepts o_inst.
- o_inst  output  32  encoded instruction.
- o_err  output  1  word flagged illegal; qualified by o_valid.
- o_err_count  output  ERR_CNT_W  saturating count of flagged words.

Behaviour:
- Reset: o_valid=0, o_err=0, o_inst=0, o_err_count=0, both stage valids 0, o_ready=1 after release. Reset mid-operation flushes in-flight entries and does not count them.
- Handshake:
  - Request accepted when i_valid&&o_ready.
  - Output consumed when o_valid&&i_ready.
  - o_valid, o_inst and o_err hold stable while o_valid&&!i_ready.
- Pipeline:
  - S1 registers the fields and computes the legality check.
  - S2 holds the assembled word.
  - Latency is 2 cycles from acceptance to o_valid; throughput is 1/cycle.
  - A stage advances when its successor is empty or being drained the same cycle. o_ready = !s1_valid || s1_advances (combinational from i_ready; no skid buffer).
  - Maximum of 2 in flight; order preserved.
- Packing (imm = i_immediate):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}; immediate ignored.
  - I: {imm[11:0],rs1,funct3,rd,opcode}.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
  - U: {imm[31:12],rd,opcode}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
- Legality (illegal = flagged):
  - I/S: imm[31:11] must be all-equal (fits signed 12).
  - B: imm[31:12] all-equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all-equal and imm[0]=0.
  - i_format zero or multi-hot is always illegal.
- o_err_count:
  - Increments on each consumed flagged word, saturating at all-ones.
  - A simultaneous consume and saturation leaves it at max.

Optional Feature:
- INST_ENCODER_RANGE_CHECK_EN.
- Defined: flagged words are replaced by the NOP 0x00000013, o_err=1, and the counter is active.
- Undefined:
  - Immediate bits are truncated silently per the packing table.
  - o_err and o_err_count are tied 0.
  - A bad i_format yields 0x00000000 with no flag.

Decomposition:
- Shared package holds:
  - Format one-hot bit indices FMT_R..FMT_J and format width 6.
  - Opcode constants (OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP).
  - INST_NOP=32'h00000013.
- One combinational sub-module, inst_pack, maps (format, fields, imm) to word and legality. It is instantiated between S1 and S2; pipeline, handshake and counter stay in the top.

Test Plan:
- addi x1,x0,-1: fmt=000010, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> o_inst=0xFFF00093 2 cycles after accept, o_err=0.
- beq x1,x2,+8: fmt=001000, op=0x63, rs1=1, rs2=2, imm=8 -> 0x00208463. lui x5: fmt=010000, op=0x37, imm=0x12345000 -> 0x123452B7.
- jal x1,+2048: fmt=100000, op=0x6F, rd=1, imm=0x800 -> 0x001000EF (imm[11] lands at bit20).
- With macro: I-type imm=2048 -> o_inst=0x00000013, o_err=1, o_err_count=1. B-type imm=6 passes; imm=7 is flagged. fmt=000110 is flagged.
- Backpressure: 3 back-to-back requests with i_ready=0 -> o_ready=0 after 2 accepted; o_inst stable; releasing i_ready delivers all 3 in order, one per cycle.
- Assert i_rst_n=0 with 2 entries in flight -> o_valid=0 and o_err_count=0 immediately; first request after release emerges 2 cycles after accept.
